// File: rtl/comp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM encodings and
// the counter-width helper.
package comp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Width of a counter that must hold WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/comp_bit_cell.sv
// Combinational 1-bit compare cell: greater / equal / less for a single bit pair.
module comp_bit_cell (
    input  logic a_i,
    input  logic b_i,
    output logic g_o,
    output logic e_o,
    output logic l_o
);

    assign g_o = a_i & ~b_i;
    assign e_o = ~(a_i ^ b_i);
    assign l_o = ~a_i & b_i;

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator: shifts operands MSB-first through one
// compare cell. Define EARLY_EXIT_EN to finish on the edge after the first differing bit.
module serial_mag_comp
    import comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CNT_W-1:0] cnt;
    logic             decided;
    logic             cell_g;
    logic             cell_e;
    logic             cell_l;
    logic             last_bit;
    logic             exit_now;

    comp_bit_cell u_cell (
        .a_i (a_sh[WIDTH-1]),
        .b_i (b_sh[WIDTH-1]),
        .g_o (cell_g),
        .e_o (cell_e),
        .l_o (cell_l)
    );

    assign last_bit = (cnt == '0);

`ifdef EARLY_EXIT_EN
    assign exit_now = last_bit || (!decided && !cell_e);
`else
    assign exit_now = last_bit;
`endif

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
        end else if (state == ST_SHIFT) begin
            // The first differing bit freezes the verdict; later bits cannot change it.
            if (!decided && !cell_e) begin
                gt      <= cell_g;
                lt      <= cell_l;
                decided <= 1'b1;
            end
            a_sh <= {a_sh[WIDTH-2:0], 1'b0};
            b_sh <= {b_sh[WIDTH-2:0], 1'b0};
            if (!last_bit) begin
                cnt <= cnt - 1'b1;
            end
            if (exit_now) begin
                state <= ST_DONE;
                eq    <= !decided && cell_e;
            end
        end else if (start) begin
            // Accepted from IDLE or DONE; a start in DONE chains back-to-back.
            state   <= ST_SHIFT;
            a_sh    <= a;
            b_sh    <= b;
            cnt     <= CNT_W'(WIDTH - 1);
            decided <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
        end else if (state == ST_DONE) begin
            state <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Scoreboard bench for serial_mag_comp (WIDTH=8); expected verdict and latency
// follow EARLY_EXIT_EN when defined.
module tb_serial_mag_comp;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         gt;
    logic         eq;
    logic         lt;

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   k;
        int   lat;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    serial_mag_comp #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--) begin
            if (x[i] != y[i]) return (W - 1 - i) + 2;
        end
`endif
        return W + 1;
    endfunction

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int k);
        exp_t e;
        e.gt  = (x > y);
        e.eq  = (x == y);
        e.lt  = (x < y);
        e.k   = k;
        e.lat = exp_lat(x, y);
        return e;
    endfunction

    // Monitor: each done pulse pops one expected verdict.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("gt", gt, e.gt);
                check("eq", eq, e.eq);
                check("lt", lt, e.lt);
                check("latency", cyc + 1 - e.k, e.lat);
            end
        end
    end

    task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        if (push) q.push_back(model(x, y, cyc + 1));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            check("timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Test 1: reset in the middle of traffic (operands differ only at LSB).
        begin
            logic [W-1:0] r;
            r = W'($urandom);
            do_start(r, r ^ 8'h01, 1'b1);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_gt", gt, 0);
        check("rst_eq", eq, 0);
        check("rst_lt", lt, 0);

        // Tests 2-4: equal, MSB-decided greater, LSB-region less.
        do_start(8'h5A, 8'h5A, 1'b1);
        wait_idle();
        do_start(8'h80, 8'h7F, 1'b1);
        wait_idle();
        do_start(8'h01, 8'h02, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("hold_lt", lt, 1);
        check("hold_gt", gt, 0);
        check("hold_eq", eq, 0);
        check("hold_done", done, 0);

        // Test 5: start while busy is ignored.
        do_start(8'h10, 8'h20, 1'b1);
        repeat (2) @(negedge clk);
        do_start(8'hFF, 8'h00, 1'b0);
        wait_idle();
        check("ignored_lt", lt, 1);
        check("ignored_gt", gt, 0);

        // Test 6: reset during SHIFT aborts, then a clean compare.
        do_start(8'h11, 8'h10, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", done, 0);
        do_start(8'h03, 8'h03, 1'b1);
        wait_idle();

        // Test 7: start during the DONE cycle chains a new compare.
        do_start(8'hA5, 8'hA4, 1'b1);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                seen = done;
            end
            check("b2b_done_seen", seen, 1);
        end
        a     = 8'h3C;
        b     = 8'hC3;
        start = 1'b1;
        q.push_back(model(8'h3C, 8'hC3, cyc + 1));
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b_busy", busy, 1);
        wait_idle();

        // A few random compares.
        for (int n = 0; n < 6; n++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = W'($urandom);
            y = (n % 3 == 0) ? x : W'($urandom);
            do_start(x, y, 1'b1);
            wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
